// File: rtl/debug_mode_ctrl_pkg.sv
// Shared types and constants for the hart debug-mode controller.
// Optional single-step support is built only when DEBUG_STEP_EN is defined.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_ENTER  = 3'd2,
        ST_HALTED = 3'd3,
        ST_RESUME = 3'd4,
        ST_STEP   = 3'd5
    } dbg_state_e;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_HOLD    = 2'b00;
    localparam cause_t CAUSE_STEP    = 2'b01;
    localparam cause_t CAUSE_HALTREQ = 2'b10;
    localparam cause_t CAUSE_EBREAK  = 2'b11;

    localparam logic [31:0] DCSR_RESET_VAL = 32'h0000_0003;

endpackage

// File: rtl/debug_mode_ctrl_if.sv
// Halt/resume handshake between the debug module and the hart controller.
interface debug_mode_ctrl_if;
    logic dm_haltreq_i;
    logic dm_resumereq_i;
    logic dm_halted_o;
    logic dm_running_o;
    logic dm_resumeack_o;
    logic dm_drain_err_o;

    modport master (
        output dm_haltreq_i, dm_resumereq_i,
        input  dm_halted_o, dm_running_o, dm_resumeack_o, dm_drain_err_o
    );

    modport slave (
        input  dm_haltreq_i, dm_resumereq_i,
        output dm_halted_o, dm_running_o, dm_resumeack_o, dm_drain_err_o
    );
endinterface

// File: rtl/debug_mode_ctrl_cause_arb.sv
// Priority encoder of halt events: ebreak > haltreq > step.
module debug_cause_arb
    import debug_pkg::*;
(
    input  logic   ebreak_evt,
    input  logic   haltreq_evt,
    input  logic   step_evt,
    output cause_t cause,
    output logic   evt_valid
);

    // Highest-priority pending event selects the cause code
    always_comb begin
        cause     = CAUSE_HOLD;
        evt_valid = 1'b0;
        if (ebreak_evt) begin
            cause     = CAUSE_EBREAK;
            evt_valid = 1'b1;
        end else if (haltreq_evt) begin
            cause     = CAUSE_HALTREQ;
            evt_valid = 1'b1;
        end else if (step_evt) begin
            cause     = CAUSE_STEP;
            evt_valid = 1'b1;
        end else begin
            cause     = CAUSE_HOLD;
            evt_valid = 1'b0;
        end
    end

endmodule

// File: rtl/debug_mode_ctrl.sv
// Hart debug-mode FSM: drain, enter, halt, resume and optional single-step.
// Macro DEBUG_STEP_EN enables the STEP state and cause 01.
module debug_mode_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    debug_mode_ctrl_if.slave   dm,
    input  logic               core_ebreak_i,
    input  logic               core_retire_i,
    input  logic               core_drained_i,
    input  logic               dcsr_step_i,
    input  logic               dcsr_ebreakm_i,
    output logic               core_halt_o,
    output logic               core_resume_o,
    output logic               DSP_reg_access_o,
    output logic [1:0]         DSP_cause_control_o,
    output logic               DSP_status_reset_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(DRAIN_TIMEOUT - 1);

    dbg_state_e state_r, state_next_s;
    logic [7:0] cnt_r;
    cause_t     cause_r;
    logic       err_r;
    logic       rst_dly_r;
    logic       status_reset_r;

    logic       ebreak_q_s;
    logic       step_evt_s;
    cause_t     arb_cause_s;
    logic       arb_valid_s;
    logic       latch_en_s;
    logic       timeout_s;

    logic       halt_s, resume_s, reg_access_s, halted_s, running_s;
    cause_t     cause_out_s;

    assign ebreak_q_s = core_ebreak_i & dcsr_ebreakm_i;

`ifdef DEBUG_STEP_EN
    assign step_evt_s = (state_r == ST_STEP) & core_retire_i;
`else
    logic step_unused_s;
    assign step_unused_s = dcsr_step_i ^ core_retire_i;
    assign step_evt_s    = 1'b0;
`endif

    debug_cause_arb u_arb (
        .ebreak_evt  (ebreak_q_s),
        .haltreq_evt (dm.dm_haltreq_i),
        .step_evt    (step_evt_s),
        .cause       (arb_cause_s),
        .evt_valid   (arb_valid_s)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        latch_en_s   = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (arb_valid_s) begin
                    state_next_s = ST_DRAIN;
                    latch_en_s   = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (core_drained_i) begin
                    state_next_s = ST_ENTER;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_next_s = ST_ENTER;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_ENTER:  state_next_s = ST_HALTED;
            ST_HALTED: begin
                if (dm.dm_resumereq_i && !dm.dm_haltreq_i) begin
                    state_next_s = ST_RESUME;
                end else begin
                    state_next_s = ST_HALTED;
                end
            end
`ifdef DEBUG_STEP_EN
            ST_RESUME: begin
                if (dcsr_step_i) begin
                    state_next_s = ST_STEP;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STEP: begin
                if (arb_valid_s) begin
                    state_next_s = ST_DRAIN;
                    latch_en_s   = 1'b1;
                end else begin
                    state_next_s = ST_STEP;
                end
            end
`else
            ST_RESUME: state_next_s = ST_RUN;
`endif
            default:   state_next_s = ST_RUN;
        endcase
    end

    // Drain counter, latched cause, sticky timeout flag and post-reset pulse
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r          <= 8'd0;
            cause_r        <= CAUSE_HOLD;
            err_r          <= 1'b0;
            rst_dly_r      <= 1'b1;
            status_reset_r <= 1'b0;
        end else begin
            cnt_r          <= (state_r == ST_DRAIN) ? cnt_r + 8'd1 : 8'd0;
            cause_r        <= latch_en_s ? arb_cause_s : cause_r;
            rst_dly_r      <= 1'b0;
            status_reset_r <= rst_dly_r;
            if (timeout_s) begin
                err_r <= 1'b1;
            end else if (state_next_s == ST_RESUME) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Output decode from the registered state
    always_comb begin
        halt_s       = 1'b0;
        resume_s     = 1'b0;
        reg_access_s = 1'b0;
        halted_s     = 1'b0;
        running_s    = 1'b0;
        cause_out_s  = CAUSE_HOLD;
        case (state_r)
            ST_RUN:    running_s = 1'b1;
            ST_DRAIN:  halt_s    = 1'b1;
            ST_ENTER: begin
                halt_s       = 1'b1;
                reg_access_s = 1'b1;
                cause_out_s  = cause_r;
            end
            ST_HALTED: begin
                halt_s       = 1'b1;
                reg_access_s = 1'b1;
                halted_s     = 1'b1;
            end
            ST_RESUME: resume_s  = 1'b1;
            ST_STEP:   running_s = 1'b1;
            default:   running_s = 1'b0;
        endcase
    end

    assign core_halt_o         = halt_s;
    assign core_resume_o       = resume_s;
    assign DSP_reg_access_o    = reg_access_s;
    assign DSP_cause_control_o = cause_out_s;
    assign DSP_status_reset_o  = status_reset_r;
    assign dm.dm_halted_o      = halted_s;
    assign dm.dm_running_o     = running_s;
    assign dm.dm_resumeack_o   = resume_s;
    assign dm.dm_drain_err_o   = err_r;

endmodule

// File: tb/tb_debug_mode_ctrl.sv
// Scoreboard bench for debug_mode_ctrl; expectations follow DEBUG_STEP_EN.
module tb_debug_mode_ctrl;

    localparam int S_RUN = 0, S_DRAIN = 1, S_ENTER = 2, S_HALTED = 3, S_RESUME = 4, S_STEP = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_ebreak, core_retire, core_drained, dcsr_step, dcsr_ebreakm;
    logic       core_halt, core_resume, reg_access, status_reset;
    logic [1:0] cause_ctrl;

    debug_mode_ctrl_if dmif ();

    debug_mode_ctrl #(.DRAIN_TIMEOUT(16)) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .dm                  (dmif),
        .core_ebreak_i       (core_ebreak),
        .core_retire_i       (core_retire),
        .core_drained_i      (core_drained),
        .dcsr_step_i         (dcsr_step),
        .dcsr_ebreakm_i      (dcsr_ebreakm),
        .core_halt_o         (core_halt),
        .core_resume_o       (core_resume),
        .DSP_reg_access_o    (reg_access),
        .DSP_cause_control_o (cause_ctrl),
        .DSP_status_reset_o  (status_reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Expected outputs {halt,resume,acc,cause[1:0],status_reset,halted,running,ack,err}
    function automatic logic [9:0] expect_vec(input int st, input logic [1:0] c,
                                              input logic sr, input logic err);
        logic [9:0] v;
        case (st)
            S_RUN:    v = {1'b0, 1'b0, 1'b0, 2'b00, sr, 1'b0, 1'b1, 1'b0, err};
            S_DRAIN:  v = {1'b1, 1'b0, 1'b0, 2'b00, sr, 1'b0, 1'b0, 1'b0, err};
            S_ENTER:  v = {1'b1, 1'b0, 1'b1, c,     sr, 1'b0, 1'b0, 1'b0, err};
            S_HALTED: v = {1'b1, 1'b0, 1'b1, 2'b00, sr, 1'b1, 1'b0, 1'b0, err};
            S_RESUME: v = {1'b0, 1'b1, 1'b0, 2'b00, sr, 1'b0, 1'b0, 1'b1, err};
            S_STEP:   v = {1'b0, 1'b0, 1'b0, 2'b00, sr, 1'b0, 1'b1, 1'b0, err};
            default:  v = 10'h3ff;
        endcase
        return v;
    endfunction

    task automatic cyc(input string nm, input int st, input logic [1:0] c = 2'b00,
                       input logic sr = 1'b0, input logic err = 1'b0);
        @(posedge clk);
        #1;
        sbq.push_back('{nm, expect_vec(st, c, sr, err)});
    endtask

    // Monitor: compare every queued expectation away from the active edge
    initial begin
        exp_t       e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e   = sbq.pop_front();
                act = {core_halt, core_resume, reg_access, cause_ctrl, status_reset,
                       dmif.dm_halted_o, dmif.dm_running_o, dmif.dm_resumeack_o,
                       dmif.dm_drain_err_o};
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %b expected %b (halt,res,acc,cause,sr,hlt,run,ack,err)",
                             e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        dmif.dm_haltreq_i = 1'b0;
        dmif.dm_resumereq_i = 1'b0;
        core_ebreak = 1'b0;
        core_retire = 1'b0;
        core_drained = 1'b1;
        dcsr_step = 1'b0;
        dcsr_ebreakm = 1'b0;

        cyc("reset0", S_RUN);
        cyc("reset1", S_RUN);
        reset = 1'b0;
        cyc("status_reset_hi", S_RUN, 2'b00, 1'b1);
        cyc("status_reset_lo", S_RUN);

        // haltreq with pipeline already drained: halted on the third edge
        dmif.dm_haltreq_i = 1'b1;
        cyc("hreq_drain", S_DRAIN);
        dmif.dm_haltreq_i = 1'b0;
        cyc("hreq_enter", S_ENTER, 2'b10);
        cyc("hreq_halted", S_HALTED);
        cyc("halted_hold", S_HALTED);

        dmif.dm_haltreq_i = 1'b1;
        dmif.dm_resumereq_i = 1'b1;
        cyc("resume_blocked", S_HALTED);
        dmif.dm_haltreq_i = 1'b0;
        cyc("resume_pulse", S_RESUME);
        dmif.dm_resumereq_i = 1'b0;
        cyc("back_run", S_RUN);

        // ebreak and haltreq together: ebreak wins
        core_ebreak = 1'b1;
        dcsr_ebreakm = 1'b1;
        dmif.dm_haltreq_i = 1'b1;
        cyc("ebk_drain", S_DRAIN);
        core_ebreak = 1'b0;
        dmif.dm_haltreq_i = 1'b0;
        cyc("ebk_enter", S_ENTER, 2'b11);
        cyc("ebk_halted", S_HALTED);
        dmif.dm_resumereq_i = 1'b1;
        cyc("ebk_resume", S_RESUME);
        dmif.dm_resumereq_i = 1'b0;
        cyc("ebk_run", S_RUN);

        // unqualified ebreak is ignored; resumereq in RUN is ignored
        dcsr_ebreakm = 1'b0;
        core_ebreak = 1'b1;
        dmif.dm_resumereq_i = 1'b1;
        cyc("ebk_ignored", S_RUN);
        core_ebreak = 1'b0;
        dmif.dm_resumereq_i = 1'b0;
        cyc("ebk_ignored2", S_RUN);

        dcsr_ebreakm = 1'b1;
        core_ebreak = 1'b1;
        cyc("ebk_only_drain", S_DRAIN);
        core_ebreak = 1'b0;
        cyc("ebk_only_enter", S_ENTER, 2'b11);
        cyc("ebk_only_halted", S_HALTED);

        // resume with dcsr.step set
        dcsr_step = 1'b1;
        dmif.dm_resumereq_i = 1'b1;
        cyc("step_resume", S_RESUME);
        dmif.dm_resumereq_i = 1'b0;
`ifdef DEBUG_STEP_EN
        cyc("step_state", S_STEP);
        cyc("step_wait", S_STEP);
        core_retire = 1'b1;
        cyc("step_drain", S_DRAIN);
        core_retire = 1'b0;
        cyc("step_enter", S_ENTER, 2'b01);
        cyc("step_halted", S_HALTED);
`else
        cyc("nostep_run", S_RUN);
        core_retire = 1'b1;
        cyc("nostep_retire", S_RUN);
        core_retire = 1'b0;
        dmif.dm_haltreq_i = 1'b1;
        cyc("nostep_drain", S_DRAIN);
        dmif.dm_haltreq_i = 1'b0;
        cyc("nostep_enter", S_ENTER, 2'b10);
        cyc("nostep_halted", S_HALTED);
`endif
        dcsr_step = 1'b0;

        // drain timeout: 16 DRAIN cycles then ENTER with the sticky error
        core_drained = 1'b0;
        dmif.dm_resumereq_i = 1'b1;
        cyc("to_resume", S_RESUME);
        dmif.dm_resumereq_i = 1'b0;
        cyc("to_run", S_RUN);
        dmif.dm_haltreq_i = 1'b1;
        cyc("to_drain_first", S_DRAIN);
        dmif.dm_haltreq_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc("to_drain_wait", S_DRAIN);
        end
        cyc("to_enter", S_ENTER, 2'b10, 1'b0, 1'b1);
        cyc("to_halted", S_HALTED, 2'b00, 1'b0, 1'b1);
        core_drained = 1'b1;
        cyc("to_err_sticky", S_HALTED, 2'b00, 1'b0, 1'b1);
        dmif.dm_resumereq_i = 1'b1;
        cyc("to_resume_clr", S_RESUME);
        dmif.dm_resumereq_i = 1'b0;
        cyc("to_run_clr", S_RUN);

        // haltreq raised during RESUME re-enters DRAIN right after RUN
        dmif.dm_haltreq_i = 1'b1;
        cyc("re_drain", S_DRAIN);
        dmif.dm_haltreq_i = 1'b0;
        cyc("re_enter", S_ENTER, 2'b10);
        cyc("re_halted", S_HALTED);
        dmif.dm_resumereq_i = 1'b1;
        cyc("re_resume", S_RESUME);
        dmif.dm_resumereq_i = 1'b0;
        dmif.dm_haltreq_i = 1'b1;
        cyc("re_run", S_RUN);
        cyc("re_drain2", S_DRAIN);
        dmif.dm_haltreq_i = 1'b0;
        cyc("re_enter2", S_ENTER, 2'b10);
        cyc("re_halted2", S_HALTED);

        // reset mid-halt aborts to RUN with no resume pulse
        reset = 1'b1;
        cyc("midhalt_reset", S_RUN);
        reset = 1'b0;
        cyc("midhalt_sr_hi", S_RUN, 2'b00, 1'b1);
        cyc("midhalt_sr_lo", S_RUN);

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
